// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: circular instruction/PC queue in front of the decoder.
// The head entry is offered to issue through a valid/ready handshake.
// Dispatch stalls while MAX_BR conditional branches are unresolved.
// A flush empties the queue and clears the branch tracking.
module fetch_queue_ctrl #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 32,
  parameter int MAX_BR = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ifetch_valid,
  input  logic [WIDTH-1:0]           ifetch_instr,
  input  logic [WIDTH-1:0]           ifetch_pc,
  output logic                       ifetch_ready,
  output logic [WIDTH-1:0]           dec_instr,
  output logic [WIDTH-1:0]           dec_pc,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  input  logic                       br_resolve,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(MAX_BR+1)-1:0] br_inflight
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(MAX_BR+1);
  localparam logic [6:0] BR_OPCODE = 7'b1100011;
  localparam logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h00000013);

  // Queue storage. The contents are never reset; only pointers and counters are.
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];

  logic [AW-1:0]    hd;
  logic [AW-1:0]    tl;
  logic [WIDTH-1:0] head_instr;
  logic [WIDTH-1:0] head_pc;
  logic             not_empty;
  logic             head_is_br;
  logic             blocked;
  logic             enq;
  logic             deq;
  logic             br_inc;
  logic             br_dec;

  assign head_instr = instr_mem[hd];
  assign head_pc    = pc_mem[hd];
  assign not_empty  = (count != '0);

  // Head decode, handshakes and the branch throttle.
  always_comb begin
    head_is_br   = not_empty && (head_instr[6:0] == BR_OPCODE);
    blocked      = head_is_br && (br_inflight == BW'(MAX_BR));
    // No pass-through: a full queue refuses even if the head leaves this cycle.
    ifetch_ready = (count != CW'(DEPTH));
    issue_valid  = not_empty && !blocked;
    enq          = ifetch_valid && ifetch_ready && !flush;
    deq          = issue_valid && issue_ready && !flush;
    br_inc       = deq && head_is_br;
    // A resolve with nothing in flight is dropped so the counter saturates at 0.
    br_dec       = br_resolve && !flush && (br_inflight != '0);
    dec_instr    = not_empty ? head_instr : NOP_INSTR;
    dec_pc       = not_empty ? head_pc    : '0;
  end

  // Write the accepted fetch entry at the tail.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[tl] <= ifetch_instr;
      pc_mem[tl]    <= ifetch_pc;
    end
  end

  // Pointer and occupancy update; flush wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else if (flush) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      if (enq) tl <= tl + AW'(1);
      if (deq) hd <= hd + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Count of dispatched branches still waiting for resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_inflight <= '0;
    end else if (flush) begin
      br_inflight <= '0;
    end else begin
      case ({br_inc, br_dec})
        2'b10:   br_inflight <= br_inflight + BW'(1);
        2'b01:   br_inflight <= br_inflight - BW'(1);
        default: br_inflight <= br_inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Bench for fetch_queue_ctrl: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fetch_queue_ctrl;
  localparam int DEPTH  = 8;
  localparam int WIDTH  = 32;
  localparam int MAX_BR = 2;
  localparam logic [31:0] BR_INSTR = 32'h00208463;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifetch_valid;
  logic [31:0] ifetch_instr;
  logic [31:0] ifetch_pc;
  logic        ifetch_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        issue_valid;
  logic        issue_ready;
  logic        br_resolve;
  logic        flush;
  logic [3:0]  count;
  logic [1:0]  br_inflight;

  fetch_queue_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_BR(MAX_BR)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifetch_valid(ifetch_valid), .ifetch_instr(ifetch_instr),
    .ifetch_pc(ifetch_pc), .ifetch_ready(ifetch_ready),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .br_resolve(br_resolve), .flush(flush),
    .count(count), .br_inflight(br_inflight)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus an in-flight branch tally.
  typedef struct { logic [31:0] instr; logic [31:0] pc; } entry_t;
  entry_t m_q[$];
  int     m_infl = 0;

  function automatic bit is_branch(input logic [31:0] ins);
    return ins[6:0] == 7'b1100011;
  endfunction

  // One cycle: drive inputs, compare outputs mid-cycle, advance the model.
  task automatic step(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ir, input bit br, input bit fl);
    bit     exp_ready, exp_valid, head_br, do_enq, do_deq;
    int     n, pre;
    entry_t e;
    ifetch_valid = iv; ifetch_instr = ins; ifetch_pc = pc;
    issue_ready = ir; br_resolve = br; flush = fl;
    @(negedge clk);
    n         = m_q.size();
    head_br   = (n > 0) && is_branch(m_q[0].instr);
    exp_ready = (n < DEPTH);
    exp_valid = (n > 0) && !(head_br && m_infl >= MAX_BR);
    check("count", 64'(count), 64'(n));
    check("br_inflight", 64'(br_inflight), 64'(m_infl));
    check("ifetch_ready", 64'(ifetch_ready), 64'(exp_ready));
    check("issue_valid", 64'(issue_valid), 64'(exp_valid));
    check("dec_instr", 64'(dec_instr), (n > 0) ? 64'(m_q[0].instr) : 64'(NOP));
    check("dec_pc", 64'(dec_pc), (n > 0) ? 64'(m_q[0].pc) : 64'd0);
    if (fl) begin
      m_q.delete();
      m_infl = 0;
    end else begin
      do_enq = iv && exp_ready;
      do_deq = exp_valid && ir;
      pre = m_infl;
      if (do_deq) begin
        if (head_br) m_infl++;
        void'(m_q.pop_front());
      end
      if (br && pre > 0) m_infl--;
      if (do_enq) begin
        e.instr = ins; e.pc = pc;
        m_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ifetch_valid = 0; ifetch_instr = 0; ifetch_pc = 0;
    issue_ready = 0; br_resolve = 0; flush = 0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(ifetch_ready), 64'd1);
    check("rst_valid", 64'(issue_valid), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'(NOP));
    check("rst_dec_pc", 64'(dec_pc), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with issue stalled, then a 9th offer that must be refused.
    for (int i = 0; i < 9; i++) step(1'b1, NOP, 32'h100 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'd8);
    check("fill_ready", 64'(ifetch_ready), 64'd0);
    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      check("drain_pc", 64'(dec_pc), 64'h100 + 64'(4*i));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    check("drain_count", 64'(count), 64'd0);

    // Streaming across pointer wrap: count holds at 1.
    step(1'b1, NOP, 32'h300, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      check("wrap_count", 64'(count), 64'd1);
      step(1'b1, NOP, 32'h300 + 32'(4*i), 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Branch throttle: third branch stalls until a resolve.
    for (int i = 0; i < 3; i++) step(1'b1, BR_INSTR, 32'h200 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("thr_valid", 64'(issue_valid), 64'd0);
    check("thr_dec_pc", 64'(dec_pc), 64'h208);
    check("thr_infl", 64'(br_inflight), 64'd2);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("thr_unblock", 64'(issue_valid), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("thr_infl2", 64'(br_inflight), 64'd2);

    // Simultaneous branch dispatch and resolve; then resolves down past zero.
    step(1'b1, BR_INSTR, 32'h400, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    check("sim_infl", 64'(br_inflight), 64'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("sat_infl", 64'(br_inflight), 64'd0);

    // Flush with everything else asserted.
    step(1'b1, BR_INSTR, 32'h500, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, NOP, 32'h504 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    check("pre_flush_count", 64'(count), 64'd5);
    step(1'b1, NOP, 32'h600, 1'b1, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_infl", 64'(br_inflight), 64'd0);
    check("flush_valid", 64'(issue_valid), 64'd0);
    check("flush_dec_instr", 64'(dec_instr), 64'(NOP));
    step(1'b1, NOP, 32'h700, 1'b0, 1'b0, 1'b0);
    check("post_flush_pc", 64'(dec_pc), 64'h700);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom();
      if ($urandom_range(2) == 0) ins[6:0] = 7'b1100011;
      step(1'($urandom_range(1)), ins, $urandom(), 1'($urandom_range(1)),
           (m_infl > 0) && ($urandom_range(3) == 0), $urandom_range(31) == 0);
    end

    // Asynchronous reset between edges with three entries queued.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, NOP, 32'h800 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    ifetch_valid = 0;
    check("pre_arst_count", 64'(count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_valid", 64'(issue_valid), 64'd0);
    check("arst_ready", 64'(ifetch_ready), 64'd1);
    m_q.delete();
    m_infl = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue_ctrl.md
# fetch_queue_ctrl

Buffers fetched instructions and their PCs in a circular FIFO in front of the instruction decoder. The head entry is presented to the decoder, and dispatch to issue uses a valid/ready handshake. Dispatch is throttled so that no more than MAX_BR unresolved conditional branches are in flight at once. A flush discards all buffered state on a redirect.

## Interface
- DEPTH, 8, queue entries; power of two, ≥2
- WIDTH, 32, instruction and PC width
- MAX_BR, 2, maximum dispatched-but-unresolved branches; ≥1
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ifetch_valid  in  1  fetch offers an entry
- ifetch_instr  in  WIDTH  fetched instruction
- ifetch_pc  in  WIDTH  PC of the fetched instruction
- ifetch_ready  out  1  queue can accept an entry
- dec_instr  out  WIDTH  head instruction, drives the decoder instruction input
- dec_pc  out  WIDTH  head PC, drives the decoder pc input
- issue_valid  out  1  head entry is dispatchable
- issue_ready  in  1  issue accepts the head entry
- br_resolve  in  1  one in-flight branch resolved this cycle
- flush  in  1  discard all entries and branch tracking
- count  out  $clog2(DEPTH+1)  occupied entries
- br_inflight  out  $clog2(MAX_BR+1)  dispatched unresolved branches

## Operation
- Storage: DEPTH entries of {pc, instr}. The head pointer (hd) and tail pointer (tl) are each log2(DEPTH) bits and wrap modulo DEPTH. The count register disambiguates full from empty.
- Branch detect: an entry is a branch when instr[6:0] == 7'b1100011 (conditional branch opcode).
- enq = ifetch_valid & ifetch_ready & ~flush. On enq, the entry is written at tl and tl increments.
- ifetch_ready = (count != DEPTH). When the queue is full, ifetch_ready stays 0 even if a dequeue occurs in the same cycle. There is no full-cycle pass-through.
- blocked = head is a branch and br_inflight == MAX_BR.
- issue_valid = (count != 0) & ~blocked.
- deq = issue_valid & issue_ready & ~flush. On deq, hd increments.
- count next value:
  - +1 on enq only
  - −1 on deq only
  - unchanged on both or neither
- br_inflight next value:
  - +1 when deq and the head is a branch
  - −1 on br_resolve
  - unchanged when both occur
  - br_resolve when br_inflight == 0 is ignored; the counter saturates at 0
- flush has highest priority:
  - hd, tl, count and br_inflight all go to 0 next cycle
  - enq, deq and br_resolve in that cycle are ignored
- dec_instr and dec_pc are combinational reads of the entry at hd.
  - When count == 0, they drive 32'h00000013 (NOP) and 0.
  - They remain valid while blocked, so the decoder sees the stalled head.
- Storage contents are not reset. Only pointers and counters are reset.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - count = 0, br_inflight = 0, hd = tl = 0
  - ifetch_ready = 1, issue_valid = 0
  - dec_instr = 32'h00000013, dec_pc = 0
- Enqueue-to-dispatch latency is 1 cycle. An entry accepted at edge N is visible at the head with issue_valid = 1 after edge N, if it is the head and not blocked. There is no same-cycle bypass from ifetch to issue.
- Throughput: 1 enq plus 1 deq per cycle in steady state when 0 < count < DEPTH.
- An issue_valid = 1, issue_ready = 0 handshake holds the head entry stable. The issue side may retract issue_ready freely. issue_valid drops only on flush, on dequeue of the last entry, or when the blocked condition is met.
- br_resolve at edge N unblocks a stalled branch head: issue_valid rises in the cycle after edge N.
- Flush at edge N: after edge N, issue_valid = 0 and ifetch_ready = 1. An entry offered in the cycle after the flush is accepted normally.
- Async reset assertion mid-operation takes effect immediately without waiting for a clock edge. Deassertion is assumed synchronous to clk externally.

## Test plan
- Fill/drain: DEPTH = 8, issue_ready = 0, enqueue 9 entries with PCs 0x100, 0x104, … → count = 8 after 8 accepts and ifetch_ready = 0 on the 9th. Then issue_ready = 1 → PCs dequeue in order 0x100…0x11C, and count returns to 0.
- Wrap-around: enqueue and dequeue continuously for 20 cycles → PC order is preserved across pointer wrap, and count stays at 1.
- Branch throttle: MAX_BR = 2, queue holds branches (instr = 32'h00208463) at 0x200, 0x204, 0x208 → the first two dispatch, then issue_valid = 0 with dec_pc = 0x208. One br_resolve pulse → issue_valid = 1 next cycle, and br_inflight reaches 2 again after dispatch.
- Simultaneous events: branch dispatch and br_resolve in the same cycle → br_inflight unchanged. br_resolve at br_inflight = 0 → stays 0.
- Flush: with count = 5, br_inflight = 1, assert flush together with ifetch_valid, issue_ready and br_resolve → next cycle count = 0, br_inflight = 0, issue_valid = 0, dec_instr = 32'h00000013, and the concurrent entry is not stored.
- Async reset: assert rst_n = 0 between clock edges with count = 3 → count = 0, issue_valid = 0 and ifetch_ready = 1 immediately, before the next edge.
